// File: rtl/adder_pkg.sv
// Types shared between the adder and its AXI-Stream client: beat layout and the
// client's output-stage state encoding.
package adder_pkg;

    localparam int DATAW = 128;

    typedef struct packed {
        logic [DATAW-1:0] tdata;
        logic             tlast;
    } adder_beat_t;

    // The state value doubles as the master tvalid bit.
    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_e;

endpackage

// File: rtl/adder_client_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; pushes while full and
// pops while empty are ignored.
module adder_client_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adder_client.sv
// AXI-Stream master feeding operand beats to the adder: FIFO, one-entry output
// register driving the master port, and delivered beat/packet counters.
module adder_client
    import adder_pkg::*;
#(
    parameter int DATAW      = adder_pkg::DATAW,
    parameter int FIFO_DEPTH = 16,
    parameter int CNTW       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATAW-1:0]              client_tdata,
    input  logic                          client_tlast,
    input  logic                          client_valid,
    output logic                          client_ready,
    output logic                          axis_adder_client_interface_tvalid,
    output logic                          axis_adder_client_interface_tlast,
    output logic [DATAW-1:0]              axis_adder_client_interface_tdata,
    input  logic                          axis_adder_client_interface_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNTW-1:0]               sent_count,
    output logic [CNTW-1:0]               packet_count,
    output logic                          busy
);

    out_state_e       state;
    logic [DATAW:0]   fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             transfer;
    logic             out_tlast;
    logic [DATAW-1:0] out_tdata;

    adder_client_fifo #(
        .WIDTH (DATAW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_data ({client_tlast, client_tdata}),
        .push      (client_valid),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Refill the output register whenever it is empty or being drained this edge.
    assign transfer = (state == OUT_SEND) & axis_adder_client_interface_tready;
    assign fifo_pop = ~fifo_empty & ((state == OUT_IDLE) | transfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= OUT_IDLE;
            out_tlast    <= 1'b0;
            out_tdata    <= '0;
            sent_count   <= '0;
            packet_count <= '0;
        end else begin
            if (transfer) begin
                sent_count <= sent_count + 1'b1;
                if (out_tlast) begin
                    packet_count <= packet_count + 1'b1;
                end
            end
            if (fifo_pop) begin
                out_tlast <= fifo_head[DATAW];
                out_tdata <= fifo_head[DATAW-1:0];
                state     <= OUT_SEND;
            end else if (transfer) begin
                state <= OUT_IDLE;
            end
        end
    end

    assign client_ready                       = ~fifo_full;
    assign axis_adder_client_interface_tvalid = (state == OUT_SEND);
    assign axis_adder_client_interface_tlast  = out_tlast;
    assign axis_adder_client_interface_tdata  = out_tdata;
    assign busy = (fifo_count != '0) | (state == OUT_SEND);

endmodule

// File: tb/tb_adder_client.sv
// Bench for adder_client: per-cycle vector table, hand-written corner sequences and a
// randomized run checked by a queue-based scoreboard.
module tb_adder_client;

    localparam int DATAW = 128;
    localparam int DEPTH = 16;
    localparam int CNTW  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [DATAW-1:0] client_tdata;
    logic             client_tlast;
    logic             client_valid;
    logic             client_ready;
    logic             tvalid;
    logic             tlast;
    logic [DATAW-1:0] tdata;
    logic             tready;
    logic [4:0]       fifo_count;
    logic [CNTW-1:0]  sent_count;
    logic [CNTW-1:0]  packet_count;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int m_sent   = 0;
    int m_pkt    = 0;
    logic [DATAW:0] exp_q[$];

    always #5 clk = ~clk;

    adder_client #(.DATAW(DATAW), .FIFO_DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk                                (clk),
        .rst                                (rst),
        .client_tdata                       (client_tdata),
        .client_tlast                       (client_tlast),
        .client_valid                       (client_valid),
        .client_ready                       (client_ready),
        .axis_adder_client_interface_tvalid (tvalid),
        .axis_adder_client_interface_tlast  (tlast),
        .axis_adder_client_interface_tdata  (tdata),
        .axis_adder_client_interface_tready (tready),
        .fifo_count                         (fifo_count),
        .sent_count                         (sent_count),
        .packet_count                       (packet_count),
        .busy                               (busy)
    );

    task automatic check_output(input string name, input logic [159:0] actual,
                                input logic [159:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle; the scoreboard sees handshakes mid-cycle and every beat
    // transferred on the master must equal the oldest accepted push.
    task automatic apply_stimulus(input logic r, input logic v, input logic [DATAW-1:0] d,
                                  input logic l, input logic rdy, output logic accepted);
        logic [DATAW:0] exp_beat;
        rst          = r;
        client_valid = v;
        client_tdata = d;
        client_tlast = l;
        tready       = rdy;
        @(negedge clk);
        accepted = v & client_ready & ~r;
        if (!r && tvalid && tready) begin
            if (exp_q.size() == 0) begin
                check_output("beat_unexpected", {tlast, tdata}, '1);
                n_fail += (({tlast, tdata}) === '1) ? 1 : 0;
            end else begin
                exp_beat = exp_q.pop_front();
                check_output("beat_data", {31'd0, tlast, tdata}, {31'd0, exp_beat});
                m_sent++;
                if (exp_beat[DATAW]) m_pkt++;
            end
        end
        if (accepted) exp_q.push_back({l, d});
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            m_sent = 0;
            m_pkt  = 0;
        end
    endtask

    task automatic idle_cycle(input logic rdy);
        logic acc;
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, rdy, acc);
    endtask

    task automatic do_reset();
        logic acc;
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       ready;
        logic       exp_tvalid;
        logic [7:0] exp_tdata;
        logic       exp_tlast;
        int         exp_sent;
        int         exp_pkt;
        int         exp_count;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic acc;
        int   next;
        int   cycles;

        // Basic packet with tready held high; each row is observed after its edge.
        vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 1};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 0, 0, 1};
        vecs[2] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1, 0, 1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 2, 0, 0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3, 1, 0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3, 1, 0};

        rst          = 1'b1;
        client_valid = 1'b1;
        client_tdata = '0;
        client_tlast = 1'b0;
        tready       = 1'b0;

        // Reset held two cycles while a push is requested.
        apply_stimulus(1'b1, 1'b1, 128'hAA, 1'b1, 1'b1, acc);
        apply_stimulus(1'b1, 1'b1, 128'hAB, 1'b1, 1'b1, acc);
        check_output("rst_tvalid", tvalid, 0);
        check_output("rst_tlast", tlast, 0);
        check_output("rst_tdata", tdata, 0);
        check_output("rst_client_ready", client_ready, 1);
        check_output("rst_fifo_count", fifo_count, 0);
        check_output("rst_sent", sent_count, 0);
        check_output("rst_packet", packet_count, 0);
        check_output("rst_busy", busy, 0);
        idle_cycle(1'b1);
        check_output("rst_nothing_enqueued", fifo_count, 0);
        check_output("rst_no_tvalid", tvalid, 0);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, vecs[i].valid, 128'(vecs[i].data), vecs[i].last,
                           vecs[i].ready, acc);
            check_output($sformatf("vec%0d_tvalid", i), tvalid, vecs[i].exp_tvalid);
            if (vecs[i].exp_tvalid) begin
                check_output($sformatf("vec%0d_tdata", i), tdata, vecs[i].exp_tdata);
                check_output($sformatf("vec%0d_tlast", i), tlast, vecs[i].exp_tlast);
            end
            check_output($sformatf("vec%0d_sent", i), sent_count, vecs[i].exp_sent);
            check_output($sformatf("vec%0d_packet", i), packet_count, vecs[i].exp_pkt);
            check_output($sformatf("vec%0d_fifo_count", i), fifo_count, vecs[i].exp_count);
        end

        // Backpressure: 0x1 goes through, then 0x2 is held for five stalled cycles.
        do_reset();
        apply_stimulus(1'b0, 1'b1, 128'h1, 1'b0, 1'b1, acc);
        apply_stimulus(1'b0, 1'b1, 128'h2, 1'b0, 1'b1, acc);
        idle_cycle(1'b1);
        check_output("bp_presented", tdata, 128'h2);
        for (int i = 0; i < 5; i++) begin
            idle_cycle(1'b0);
            check_output($sformatf("bp_hold_tdata%0d", i), tdata, 128'h2);
            check_output($sformatf("bp_hold_tvalid%0d", i), tvalid, 1);
            check_output($sformatf("bp_hold_sent%0d", i), sent_count, 1);
        end
        idle_cycle(1'b1);
        check_output("bp_released_sent", sent_count, 2);
        check_output("bp_released_tvalid", tvalid, 0);

        // Fill to capacity with the master stalled.
        do_reset();
        next = 0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 1'b1, 128'(32'h100 + i), 1'b0, 1'b0, acc);
            if (acc) next++;
        end
        check_output("full_accepted", next, DEPTH + 1);
        check_output("full_fifo_count", fifo_count, DEPTH);
        check_output("full_client_ready", client_ready, 0);
        check_output("full_head_beat", tdata, 128'h100);
        apply_stimulus(1'b0, 1'b1, 128'hDEAD, 1'b0, 1'b1, acc);
        check_output("full_push_refused", fifo_count, DEPTH - 1);
        check_output("full_ready_after_xfer", client_ready, 1);
        cycles = 0;
        while (busy && cycles < 40) begin
            idle_cycle(1'b1);
            cycles++;
        end
        check_output("full_drained", busy, 0);
        check_output("full_drain_sent", sent_count, DEPTH + 1);

        // Reset arriving after two of three beats have transferred.
        do_reset();
        apply_stimulus(1'b0, 1'b1, 128'h11, 1'b0, 1'b1, acc);
        apply_stimulus(1'b0, 1'b1, 128'h12, 1'b0, 1'b1, acc);
        apply_stimulus(1'b0, 1'b1, 128'h13, 1'b1, 1'b1, acc);
        idle_cycle(1'b1);
        check_output("midrst_before_sent", sent_count, 2);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, acc);
        check_output("midrst_tvalid", tvalid, 0);
        check_output("midrst_sent", sent_count, 0);
        check_output("midrst_fifo_count", fifo_count, 0);
        apply_stimulus(1'b0, 1'b1, 128'h5, 1'b0, 1'b0, acc);
        idle_cycle(1'b0);
        check_output("midrst_next_tvalid", tvalid, 1);
        check_output("midrst_next_tdata", tdata, 128'h5);
        idle_cycle(1'b1);

        // Randomized run: 40 beats, tlast on every third, random valid/ready.
        do_reset();
        next   = 0;
        cycles = 0;
        while (m_sent < 40 && cycles < 2000) begin
            apply_stimulus(1'b0, (next < 40) && ($urandom_range(3) != 0),
                           128'(32'h1000 + next), (next % 3) == 2,
                           $urandom_range(2) != 0, acc);
            if (acc) next++;
            cycles++;
        end
        check_output("rand_all_received", m_sent, 40);
        check_output("rand_sent", sent_count, 40);
        check_output("rand_packet", packet_count, 13);
        check_output("rand_model_packets", m_pkt, 13);
        check_output("rand_queue_empty", exp_q.size(), 0);
        idle_cycle(1'b1);
        check_output("rand_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_client.md
# adder_client

AXI-Stream master that feeds operand beats into the adder's `axis_adder_interface` slave port. Upstream logic pushes 128-bit operands, each with a last flag, into an internal FIFO. The block replays them on the master interface with full tvalid/tready handshaking, one beat per cycle when unstalled. It also counts delivered beats and packets.

## Interface
Parameters:
- `DATAW`, 128, operand/beat width
- `FIFO_DEPTH`, 16, operand FIFO entries; power of two, ≥2
- `CNTW`, 32, width of beat/packet counters

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `client_tdata`  in  DATAW  operand to enqueue
- `client_tlast`  in  1  operand is final beat of a packet
- `client_valid`  in  1  push request
- `client_ready`  out  1  FIFO not full; push accepted on edge where `client_valid & client_ready`
- `axis_adder_client_interface_tvalid`  out  1  master beat valid
- `axis_adder_client_interface_tlast`  out  1  master beat is last of packet
- `axis_adder_client_interface_tdata`  out  DATAW  master beat data
- `axis_adder_client_interface_tready`  in  1  adder accepts beat
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries held in FIFO (excludes output register)
- `sent_count`  out  CNTW  beats transferred on master since reset
- `packet_count`  out  CNTW  beats transferred with tlast=1 since reset
- `busy`  out  1  `fifo_count != 0 | tvalid`

## Operation
- Two-level buffering: FIFO (FIFO_DEPTH entries) → output register (1 entry) → master port. Total capacity is FIFO_DEPTH+1 beats.
- Output FSM, state held in the output register valid bit:
  - IDLE (tvalid=0): if the FIFO is non-empty, pop the head into the output register and go to SEND.
  - SEND (tvalid=1): on `tready=1`, the beat transfers and `sent_count` increments. `packet_count` also increments if tlast=1. Then:
    - FIFO non-empty: pop the next head in the same edge and stay in SEND (no bubble).
    - FIFO empty: go to IDLE.
  - SEND with `tready=0`: hold `tdata`/`tlast`/`tvalid` unchanged. No pop.
- tvalid never depends combinationally on tready. Once asserted, it drops only after a transfer or a reset.
- `tlast` passes through unchanged from the pushed beat. The block does not form or check packets.
- FIFO behaviour:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - `fifo_count` tracks occupancy. A simultaneous push and pop leaves the count unchanged.
  - `client_ready = (fifo_count != FIFO_DEPTH)`, derived from registered count. When full, a push is refused even if a pop happens on the same edge.
  - Pop from an empty FIFO never occurs. Push while not ready is ignored.
- Counters wrap modulo 2^CNTW.
- Reset, any cycle including mid-packet: clears FIFO pointers and count, output register, and both counters. Beats in flight are discarded.

## Timing
- Reset values: `tvalid=0`, `tlast=0`, `tdata=0`, `client_ready=1`, `fifo_count=0`, `sent_count=0`, `packet_count=0`, `busy=0`.
- Latency: a push accepted at edge E appears in `fifo_count` after E. `tvalid` asserts after edge E+1, with that beat's data.
- Throughput: 1 beat/cycle sustained while tready=1 and the FIFO is non-empty.
- Counters update on the edge of transfer and are visible the following cycle.
- `rst` sampled high at edge E: all outputs show reset values after E, regardless of other inputs at E.

## Structure
- Shared package `adder_pkg`: `DATAW` default (128), typedef `adder_beat_t` {tdata[DATAW], tlast}, shared with the adder.
- Sub-module `adder_client_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count. The top holds the output register, FSM and counters.

## Test plan
- Reset: hold `rst` 2 cycles with `client_valid=1` → all outputs at reset values; nothing enqueued; `client_ready=1`.
- Basic packet: tready=1; push 0x1, 0x2, 0x3 (tlast on 0x3) on consecutive edges → master beats 0x1, 0x2, 0x3 on 3 consecutive cycles, first one 2 edges after the push of 0x1; tlast only with 0x3; `sent_count=3`, `packet_count=1`.
- Backpressure: beat 0x2 presented, tready=0 for 5 cycles → tdata stays 0x2 and tvalid stays 1; counters unchanged; transfer on the first tready=1 edge.
- Full: tready=0, push continuously with FIFO_DEPTH=16 → 17 beats accepted; `client_ready=0` with `fifo_count=16`. One transfer → `client_ready=1` the next cycle.
- Reset mid-packet: after 2 of 3 beats transfer, pulse `rst` → tvalid=0 and counts 0 the next cycle. A subsequent push of 0x5 comes out first, as 0x5.
- Wrap-around: 40 incrementing beats, pseudo-random tready and client_valid → all 40 received in order, no duplicates or drops; `sent_count=40`; every third beat has tlast, giving `packet_count=13`.
